// File: rtl/rs_pkg.sv
// Shared constants for the RS(15,11) encoder: field size, code dimensions,
// generator coefficients and FSM state encoding.
package rs_pkg;

    localparam int M    = 4;
    localparam int F    = 'b1001;
    localparam int N    = (1 << M) - 1;
    localparam int K    = 11;
    localparam int NPAR = N - K;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
    localparam int G0 = 7;
    localparam int G1 = 8;
    localparam int G2 = 12;
    localparam int G3 = 13;

    localparam logic [0:0] ST_DATA   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

endpackage

// File: rtl/rs_encoder_if.sv
// Symbol stream bus of the RS encoder: input handshake plus output
// handshake with sop/eop/parity framing flags.
interface rs_encoder_if #(
    parameter int M = rs_pkg::M
);
    logic [M-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic         out_par;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_par
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_par
    );
endinterface

// File: rtl/rs_gf_cmul.sv
// Multiply a GF(2^M) symbol by the constant C; C is taken in the polynomial
// basis, so the product is the XOR of a*alpha^i over the set bits of C.
module rs_gf_cmul #(
    parameter int M = rs_pkg::M,
    parameter int F = rs_pkg::F,
    parameter int C = 1
) (
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);
    localparam logic [M-1:0] FM = M'(F);

    logic [M-1:0] term;

    always_comb begin
        y    = '0;
        term = a;
        for (int i = 0; i < M; i++) begin
            if (C[i]) y = y ^ term;
            // term * alpha: fold F in when the top bit overflows, wrap msb to bit 0
            term = {term[M-2:0] ^ (FM[M-2:0] & {(M-1){term[M-1]}}), term[M-1]};
        end
    end
endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(15,11) encoder over GF(16): data passes through, then four
// parity symbols from a 4-stage LFSR. Optional feature: RS_ENC_ERR_INJECT_EN.
//
//   state     | meaning
//   ST_DATA   | pass message symbols through and clock them into the LFSR
//   ST_PARITY | shift the four parity symbols out of the LFSR
module rs_encoder #(
    parameter int M = rs_pkg::M,
    parameter int F = rs_pkg::F,
    parameter int K = rs_pkg::K
) (
    input logic clk,
    input logic rst_n,
`ifdef RS_ENC_ERR_INJECT_EN
    input logic         inj_en,
    input logic [M-1:0] inj_pos,
    input logic [M-1:0] inj_val,
`endif
    rs_encoder_if.slave bus
);
    import rs_pkg::G0;
    import rs_pkg::G1;
    import rs_pkg::G2;
    import rs_pkg::G3;
    import rs_pkg::ST_DATA;
    import rs_pkg::ST_PARITY;

    localparam int N    = (1 << M) - 1;
    localparam int NPAR = N - K;

    localparam logic [M-1:0] DATA_LAST = M'(K - 1);
    localparam logic [M-1:0] PAR_LAST  = M'(NPAR - 1);

    logic [0:0]   state;
    logic [M-1:0] cnt;
    logic [M-1:0] r0, r1, r2, r3;
    logic [M-1:0] fb, p0, p1, p2, p3;
    logic [M-1:0] od;
    logic         ov, os, oe, op;
    logic         adv, in_ready_i, xfer;
    logic [M-1:0] sym_err;

    assign adv        = !ov || bus.out_ready;
    assign in_ready_i = (state == ST_DATA) && adv;
    assign xfer       = bus.in_valid && in_ready_i;
    assign fb         = bus.in_data ^ r3;

    rs_gf_cmul #(.M(M), .F(F), .C(G0)) u_mul0 (.a(fb), .y(p0));
    rs_gf_cmul #(.M(M), .F(F), .C(G1)) u_mul1 (.a(fb), .y(p1));
    rs_gf_cmul #(.M(M), .F(F), .C(G2)) u_mul2 (.a(fb), .y(p2));
    rs_gf_cmul #(.M(M), .F(F), .C(G3)) u_mul3 (.a(fb), .y(p3));

`ifdef RS_ENC_ERR_INJECT_EN
    localparam logic [M-1:0] K_OFS = M'(K);

    logic         inj_en_q;
    logic [M-1:0] inj_pos_q, inj_val_q;
    logic         first_sym, eff_en;
    logic [M-1:0] eff_pos, eff_val, idx;

    // Symbol 0 uses the live inj_* inputs; the rest of the codeword the captured copy.
    always_comb begin
        first_sym = (state == ST_DATA) && (cnt == '0);
        eff_en    = first_sym ? inj_en  : inj_en_q;
        eff_pos   = first_sym ? inj_pos : inj_pos_q;
        eff_val   = first_sym ? inj_val : inj_val_q;
        idx       = (state == ST_PARITY) ? cnt + K_OFS : cnt;
        sym_err   = (eff_en && (eff_pos == idx)) ? eff_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
            inj_val_q <= '0;
        end else if (xfer && (cnt == '0)) begin
            inj_en_q  <= inj_en;
            inj_pos_q <= inj_pos;
            inj_val_q <= inj_val;
        end
    end
`else
    assign sym_err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DATA;
            cnt   <= '0;
            r0    <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            od    <= '0;
            ov    <= 1'b0;
            os    <= 1'b0;
            oe    <= 1'b0;
            op    <= 1'b0;
        end else if (state == ST_DATA) begin
            if (xfer) begin
                od <= bus.in_data ^ sym_err;
                ov <= 1'b1;
                op <= 1'b0;
                os <= (cnt == '0);
                oe <= 1'b0;
                r3 <= r2 ^ p3;
                r2 <= r1 ^ p2;
                r1 <= r0 ^ p1;
                r0 <= p0;
                if (cnt == DATA_LAST) begin
                    state <= ST_PARITY;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (adv) begin
                ov <= 1'b0;
            end
        end else if (adv) begin
            od <= r3 ^ sym_err;
            ov <= 1'b1;
            op <= 1'b1;
            os <= 1'b0;
            oe <= (cnt == PAR_LAST);
            r3 <= r2;
            r2 <= r1;
            r1 <= r0;
            r0 <= '0;
            if (cnt == PAR_LAST) begin
                state <= ST_DATA;
                cnt   <= '0;
                r3    <= '0;
                r2    <= '0;
                r1    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.out_data  = od;
    assign bus.out_valid = ov;
    assign bus.out_sop   = os;
    assign bus.out_eop   = oe;
    assign bus.out_par   = op;

endmodule

// File: tb/tb_rs_encoder.sv
// Directed and randomized bench for rs_encoder; codewords are checked by
// pass-through, framing flags and syndromes computed with an independent GF model.
module tb_rs_encoder;

    typedef logic [3:0] msg_t [11];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_encoder_if #(.M(4)) bus ();

`ifdef RS_ENC_ERR_INJECT_EN
    logic       inj_en  = 1'b0;
    logic [3:0] inj_pos = 4'd0;
    logic [3:0] inj_val = 4'd0;
`endif

    rs_encoder #(.M(4), .F('b1001), .K(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RS_ENC_ERR_INJECT_EN
        .inj_en  (inj_en),
        .inj_pos (inj_pos),
        .inj_val (inj_val),
`endif
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_rdy = 1'b0;

    logic [3:0] cap_d [$];
    logic [2:0] cap_f [$];   // {sop, eop, par}
    int         cap_c [$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            cap_d.push_back(bus.out_data);
            cap_f.push_back({bus.out_sop, bus.out_eop, bus.out_par});
            cap_c.push_back(cyc);
        end
    end

    // Reference multiply in GF(2^4) with x^4 + x + 1, alpha = 2.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, x;
        p = 4'd0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [3:0] syn(input int base, input int j);
        logic [3:0] aj, s;
        aj = 4'd1;
        for (int i = 0; i < j; i++) aj = gf_mul(aj, 4'd2);
        s = 4'd0;
        for (int i = 0; i < 15; i++) s = gf_mul(s, aj) ^ cap_d[base+i];
        return s;
    endfunction

    function automatic logic [2:0] exp_flags(input int i);
        return {i == 0, i == 14, i >= 11};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic send(input msg_t msg, input int n, input bit rnd_v);
        bit go;
        int budget;
        for (int i = 0; i < n; i++) begin
            if (rnd_v) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    tick();
                end
            end
            bus.in_data  = msg[i];
            bus.in_valid = 1'b1;
            budget = 0;
            forever begin
                go = bus.in_ready;
                tick();
                if (go) break;
                budget++;
                if (budget > 200) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: symbol %0d never accepted", i);
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int target, input int budget);
        int b;
        b = 0;
        while (cap_d.size() < target) begin
            tick();
            b++;
            if (b > budget) begin
                checks++; errors++;
                $display("FAIL drain_timeout: got %0d symbols, required %0d", cap_d.size(), target);
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_data = 4'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_par} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000",
                     {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_par});
        end
        checks++;
        if (bus.out_data !== 4'd0) begin
            errors++; $display("FAIL reset_data: got %0d required 0", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        msg_t m;
        int base;
        for (int i = 0; i < 11; i++) m[i] = 4'd0;
        base = cap_d.size();
        send(m, 11, 1'b0);
        drain(base + 15, 100);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (cap_d[base+i] !== 4'd0) begin
                errors++; $display("FAIL zero_data[%0d]: got %0d required 0", i, cap_d[base+i]);
            end
            checks++;
            if (cap_f[base+i] !== exp_flags(i)) begin
                errors++;
                $display("FAIL zero_flags[%0d]: got %b required %b", i, cap_f[base+i], exp_flags(i));
            end
        end
    endtask

    task automatic test_impulse();
        msg_t m;
        int base;
        logic [3:0] exp [15];
        logic [3:0] par [4];
        par[0] = 4'd13; par[1] = 4'd12; par[2] = 4'd8; par[3] = 4'd7;
        for (int i = 0; i < 11; i++) m[i] = (i == 10) ? 4'd1 : 4'd0;
        for (int i = 0; i < 15; i++) exp[i] = (i < 11) ? m[i] : par[i-11];
        base = cap_d.size();
        send(m, 11, 1'b0);
        drain(base + 15, 100);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (cap_d[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL impulse_data[%0d]: got %0d required %0d", i, cap_d[base+i], exp[i]);
            end
        end
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (syn(base, j) !== 4'd0) begin
                errors++; $display("FAIL impulse_S%0d: got %0d required 0", j, syn(base, j));
            end
        end
    endtask

    task automatic test_back_to_back();
        msg_t a, b;
        int base;
        for (int i = 0; i < 11; i++) begin
            a[i] = 4'(i + 1);
            b[i] = 4'(15 - i);
        end
        base = cap_d.size();
        send(a, 11, 1'b0);
        send(b, 11, 1'b0);
        drain(base + 30, 100);
        checks++;
        if (cap_c[base+29] - cap_c[base] !== 29) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles required 29", cap_c[base+29] - cap_c[base]);
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (cap_d[base+15*c+i] !== (c == 0 ? a[i] : b[i])) begin
                    errors++;
                    $display("FAIL b2b_data[%0d][%0d]: got %0d required %0d", c, i,
                             cap_d[base+15*c+i], (c == 0 ? a[i] : b[i]));
                end
            end
            for (int j = 1; j <= 4; j++) begin
                checks++;
                if (syn(base + 15*c, j) !== 4'd0) begin
                    errors++;
                    $display("FAIL b2b_S%0d[%0d]: got %0d required 0", j, c, syn(base + 15*c, j));
                end
            end
        end
    endtask

    task automatic test_stall();
        msg_t m;
        int base, b;
        for (int i = 0; i < 11; i++) m[i] = (i == 10) ? 4'd1 : 4'd0;
        base = cap_d.size();
        send(m, 11, 1'b0);
        b = 0;
        while (cap_d.size() < base + 13 && b < 100) begin tick(); b++; end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_par, bus.out_eop, bus.out_data} !== {3'b110, 4'd8}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v/par/eop/data %b/%b/%b/%0d required 1/1/0/8",
                         k, bus.out_valid, bus.out_par, bus.out_eop, bus.out_data);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready[%0d]: got %b required 0", k, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        drain(base + 15, 100);
        repeat (3) tick();
        checks++;
        if (cap_d.size() !== base + 15) begin
            errors++; $display("FAIL stall_count: got %0d required %0d", cap_d.size() - base, 15);
        end
        checks++;
        if ({cap_d[base+11], cap_d[base+12], cap_d[base+13], cap_d[base+14]} !== {4'd13, 4'd12, 4'd8, 4'd7}) begin
            errors++;
            $display("FAIL stall_parity: got %0d %0d %0d %0d required 13 12 8 7",
                     cap_d[base+11], cap_d[base+12], cap_d[base+13], cap_d[base+14]);
        end
    endtask

    task automatic test_reset_mid();
        msg_t m1, m2;
        int base;
        for (int i = 0; i < 11; i++) begin
            m1[i] = 4'(3 * i + 2);
            m2[i] = 4'(7 * i + 5);
        end
        send(m1, 7, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_par, bus.out_data, bus.in_ready} !== 9'b0000_0000_1) begin
            errors++;
            $display("FAIL midreset_outputs: got v/s/e/p/data/in_ready %b/%b/%b/%b/%0d/%b required 0/0/0/0/0/1",
                     bus.out_valid, bus.out_sop, bus.out_eop, bus.out_par, bus.out_data, bus.in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base = cap_d.size();
        send(m2, 11, 1'b0);
        drain(base + 15, 100);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (cap_f[base+i] !== exp_flags(i) || (i < 11 && cap_d[base+i] !== m2[i])) begin
                errors++;
                $display("FAIL midreset_sym[%0d]: got %0d/%b required %0d/%b", i, cap_d[base+i],
                         cap_f[base+i], (i < 11 ? m2[i] : 4'd0), exp_flags(i));
            end
        end
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (syn(base, j) !== 4'd0) begin
                errors++; $display("FAIL midreset_S%0d: got %0d required 0", j, syn(base, j));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] rmsg [100][11];
        msg_t m;
        int base, bad;
        base = cap_d.size();
        rnd_rdy = 1'b1;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < 11; i++) begin
                rmsg[c][i] = 4'($urandom_range(0, 15));
                m[i] = rmsg[c][i];
            end
            send(m, 11, 1'b1);
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain(base + 1500, 200);
        for (int c = 0; c < 100; c++) begin
            bad = 0;
            for (int i = 0; i < 15; i++) begin
                if (cap_f[base+15*c+i] !== exp_flags(i)) bad++;
                if (i < 11 && cap_d[base+15*c+i] !== rmsg[c][i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL random_cw[%0d]: got %0d bad symbols required 0", c, bad);
            end
            for (int j = 1; j <= 4; j++) begin
                checks++;
                if (syn(base + 15*c, j) !== 4'd0) begin
                    errors++;
                    $display("FAIL random_S%0d[%0d]: got %0d required 0", j, c, syn(base + 15*c, j));
                end
            end
        end
    endtask

`ifdef RS_ENC_ERR_INJECT_EN
    task automatic test_inject();
        msg_t m;
        int base;
        for (int i = 0; i < 11; i++) m[i] = 4'd0;
        base = cap_d.size();
        inj_en = 1'b1; inj_pos = 4'd3; inj_val = 4'd5;
        send(m, 11, 1'b0);
        inj_pos = 4'd15;
        send(m, 11, 1'b0);
        inj_en = 1'b0;
        drain(base + 30, 100);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (cap_d[base+i] !== ((i == 3) ? 4'd5 : 4'd0)) begin
                errors++;
                $display("FAIL inject_data[%0d]: got %0d required %0d", i, cap_d[base+i],
                         ((i == 3) ? 4'd5 : 4'd0));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef RS_ENC_ERR_INJECT_EN
        test_inject();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
